// File: rtl/pipeline_defs_pkg.sv
`default_nettype none
// ============================================================================
// Module : pipeline_defs_pkg
// Brief  : Shared op codes, memory-stage state encoding and op-class helpers.
// Rev    : 1.0  initial release
// ============================================================================
package pipeline_defs_pkg;

    localparam logic [7:0] c_op_lb  = 8'hE0;
    localparam logic [7:0] c_op_lh  = 8'hE1;
    localparam logic [7:0] c_op_lw  = 8'hE3;
    localparam logic [7:0] c_op_lbu = 8'hE4;
    localparam logic [7:0] c_op_lhu = 8'hE5;
    localparam logic [7:0] c_op_sb  = 8'hE8;
    localparam logic [7:0] c_op_sh  = 8'hE9;
    localparam logic [7:0] c_op_sw  = 8'hEB;

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_BUS  = 1'b1
    } mem_state_t;

    function automatic logic is_load(input logic [7:0] op);
        return (op == c_op_lb) || (op == c_op_lh) || (op == c_op_lw) ||
               (op == c_op_lbu) || (op == c_op_lhu);
    endfunction

    function automatic logic is_store(input logic [7:0] op);
        return (op == c_op_sb) || (op == c_op_sh) || (op == c_op_sw);
    endfunction

endpackage
`default_nettype wire

// File: rtl/mem_lane_align.sv
`default_nettype none
// ============================================================================
// Module : mem_lane_align
// Brief  : Big-endian byte-lane select, store replication, load extract and
//          sign/zero extension, plus misalignment detection.
// Rev    : 1.0  initial release
// ============================================================================
module mem_lane_align
    import pipeline_defs_pkg::*;
(
    input  logic [7:0]  op,
    input  logic [1:0]  addr_lo,
    input  logic [31:0] store_data,
    input  logic [31:0] rdata,
    output logic [3:0]  sel,
    output logic [31:0] wdata,
    output logic [31:0] load_data,
    output logic        misalign
);

    logic w_is_byte;
    logic w_is_half;
    logic w_is_word;
    logic w_signed;
    logic [7:0]  w_byte;
    logic [15:0] w_half;

    assign w_is_byte = (op == c_op_lb) || (op == c_op_lbu) || (op == c_op_sb);
    assign w_is_half = (op == c_op_lh) || (op == c_op_lhu) || (op == c_op_sh);
    assign w_is_word = (op == c_op_lw) || (op == c_op_sw);
    assign w_signed  = (op == c_op_lb) || (op == c_op_lh);

    assign misalign = (w_is_half && addr_lo[0]) || (w_is_word && (addr_lo != 2'b00));

    // Lane 0 of the address is the most significant byte of the bus word.
    always_comb begin
        w_byte = rdata[31:24];
        case (addr_lo)
            2'b00:   w_byte = rdata[31:24];
            2'b01:   w_byte = rdata[23:16];
            2'b10:   w_byte = rdata[15:8];
            default: w_byte = rdata[7:0];
        endcase
    end

    assign w_half = addr_lo[1] ? rdata[15:0] : rdata[31:16];

    always_comb begin
        sel       = 4'b0000;
        wdata     = store_data;
        load_data = rdata;
        if (w_is_byte) begin
            sel       = 4'b1000 >> addr_lo;
            wdata     = {4{store_data[7:0]}};
            load_data = {{24{w_signed & w_byte[7]}}, w_byte};
        end else if (w_is_half) begin
            sel       = addr_lo[1] ? 4'b0011 : 4'b1100;
            wdata     = {2{store_data[15:0]}};
            load_data = {{16{w_signed & w_half[15]}}, w_half};
        end else if (w_is_word) begin
            sel       = 4'b1111;
        end
    end

endmodule
`default_nettype wire

// File: rtl/mem_stage.sv
`default_nettype none
// ============================================================================
// Module : mem_stage
// Brief  : Pipeline memory stage; holds the EX/MEM register and runs a
//          stalling req/ack bus transaction for loads and stores.
// Rev    : 1.0  initial release
// ============================================================================
module mem_stage
    import pipeline_defs_pkg::*;
#(
    parameter int ACK_TIMEOUT = 64
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [7:0]  alu_op_i,
    input  logic        write_reg_en_i,
    input  logic [4:0]  write_reg_addr_i,
    input  logic [31:0] write_reg_data_i,
    input  logic [31:0] mem_addr_i,
    input  logic [31:0] mem_store_data_i,
    input  logic        flush_i,
    output logic        mem_req_o,
    output logic        mem_we_o,
    output logic [31:0] mem_addr_o,
    output logic [3:0]  mem_sel_o,
    output logic [31:0] mem_wdata_o,
    input  logic [31:0] mem_rdata_i,
    input  logic        mem_ack_i,
    output logic        write_reg_en_o,
    output logic [4:0]  write_reg_addr_o,
    output logic [31:0] write_reg_data_o,
    output logic        stall_req_o,
    output logic        misalign_o,
    output logic        bus_err_o
);

    localparam int c_cnt_w = $clog2(ACK_TIMEOUT);

    mem_state_t         r_state;
    logic [c_cnt_w-1:0] r_cnt;
    logic [7:0]         r_op;
    logic [1:0]         r_addr_lo;
    logic               r_dest_en;
    logic               r_flushed;

    logic [7:0]  w_align_op;
    logic [1:0]  w_align_lo;
    logic [3:0]  w_sel;
    logic [31:0] w_wdata;
    logic [31:0] w_load_data;
    logic        w_misalign;
    logic        w_is_mem;

    // One aligner serves both phases: issue decode in IDLE, load extract in BUS.
    assign w_align_op = (r_state == ST_BUS) ? r_op : alu_op_i;
    assign w_align_lo = (r_state == ST_BUS) ? r_addr_lo : mem_addr_i[1:0];
    assign w_is_mem   = is_load(alu_op_i) || is_store(alu_op_i);

    mem_lane_align u_align (
        .op         (w_align_op),
        .addr_lo    (w_align_lo),
        .store_data (mem_store_data_i),
        .rdata      (mem_rdata_i),
        .sel        (w_sel),
        .wdata      (w_wdata),
        .load_data  (w_load_data),
        .misalign   (w_misalign)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state          <= ST_IDLE;
            r_cnt            <= '0;
            r_op             <= '0;
            r_addr_lo        <= '0;
            r_dest_en        <= 1'b0;
            r_flushed        <= 1'b0;
            mem_req_o        <= 1'b0;
            mem_we_o         <= 1'b0;
            mem_addr_o       <= '0;
            mem_sel_o        <= '0;
            mem_wdata_o      <= '0;
            write_reg_en_o   <= 1'b0;
            write_reg_addr_o <= '0;
            write_reg_data_o <= '0;
            stall_req_o      <= 1'b0;
            misalign_o       <= 1'b0;
            bus_err_o        <= 1'b0;
        end else begin
            misalign_o <= 1'b0;
            bus_err_o  <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    write_reg_en_o   <= 1'b0;
                    write_reg_addr_o <= write_reg_addr_i;
                    write_reg_data_o <= write_reg_data_i;
                    if (flush_i) begin
                        write_reg_en_o <= 1'b0;
                    end else if (!w_is_mem) begin
                        write_reg_en_o <= write_reg_en_i;
                    end else if (w_misalign) begin
                        misalign_o <= 1'b1;
                    end else begin
                        r_state     <= ST_BUS;
                        r_cnt       <= '0;
                        r_op        <= alu_op_i;
                        r_addr_lo   <= mem_addr_i[1:0];
                        r_dest_en   <= write_reg_en_i;
                        r_flushed   <= 1'b0;
                        mem_req_o   <= 1'b1;
                        mem_we_o    <= is_store(alu_op_i);
                        mem_addr_o  <= {mem_addr_i[31:2], 2'b00};
                        mem_sel_o   <= w_sel;
                        mem_wdata_o <= w_wdata;
                        stall_req_o <= 1'b1;
                    end
                end
                ST_BUS: begin
                    if (flush_i) begin
                        r_flushed <= 1'b1;
                    end
                    // Ack is checked first so a same-cycle timeout loses.
                    if (mem_ack_i || (r_cnt == c_cnt_w'(ACK_TIMEOUT - 1))) begin
                        r_state     <= ST_IDLE;
                        r_cnt       <= '0;
                        mem_req_o   <= 1'b0;
                        mem_we_o    <= 1'b0;
                        mem_addr_o  <= '0;
                        mem_sel_o   <= '0;
                        mem_wdata_o <= '0;
                        stall_req_o <= 1'b0;
                        if (mem_ack_i) begin
                            write_reg_en_o   <= is_load(r_op) && r_dest_en &&
                                                !(flush_i || r_flushed);
                            write_reg_data_o <= w_load_data;
                        end else begin
                            write_reg_en_o <= 1'b0;
                            bus_err_o      <= 1'b1;
                        end
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_mem_stage.sv
`default_nettype none
// ============================================================================
// Module : tb_mem_stage
// Brief  : Directed self-checking bench for mem_stage (ACK_TIMEOUT = 8).
// Rev    : 1.0  initial release
// ============================================================================
module tb_mem_stage;

    logic        clk = 1'b0;
    logic        rst;
    logic [7:0]  alu_op_i;
    logic        write_reg_en_i;
    logic [4:0]  write_reg_addr_i;
    logic [31:0] write_reg_data_i;
    logic [31:0] mem_addr_i;
    logic [31:0] mem_store_data_i;
    logic        flush_i;
    logic        mem_req_o;
    logic        mem_we_o;
    logic [31:0] mem_addr_o;
    logic [3:0]  mem_sel_o;
    logic [31:0] mem_wdata_o;
    logic [31:0] mem_rdata_i;
    logic        mem_ack_i;
    logic        write_reg_en_o;
    logic [4:0]  write_reg_addr_o;
    logic [31:0] write_reg_data_o;
    logic        stall_req_o;
    logic        misalign_o;
    logic        bus_err_o;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    mem_stage #(.ACK_TIMEOUT(8)) dut (
        .clk              (clk),
        .rst              (rst),
        .alu_op_i         (alu_op_i),
        .write_reg_en_i   (write_reg_en_i),
        .write_reg_addr_i (write_reg_addr_i),
        .write_reg_data_i (write_reg_data_i),
        .mem_addr_i       (mem_addr_i),
        .mem_store_data_i (mem_store_data_i),
        .flush_i          (flush_i),
        .mem_req_o        (mem_req_o),
        .mem_we_o         (mem_we_o),
        .mem_addr_o       (mem_addr_o),
        .mem_sel_o        (mem_sel_o),
        .mem_wdata_o      (mem_wdata_o),
        .mem_rdata_i      (mem_rdata_i),
        .mem_ack_i        (mem_ack_i),
        .write_reg_en_o   (write_reg_en_o),
        .write_reg_addr_o (write_reg_addr_o),
        .write_reg_data_o (write_reg_data_o),
        .stall_req_o      (stall_req_o),
        .misalign_o       (misalign_o),
        .bus_err_o        (bus_err_o)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive_idle();
        alu_op_i         = 8'h00;
        write_reg_en_i   = 1'b0;
        write_reg_addr_i = 5'd0;
        write_reg_data_i = 32'h0;
        mem_addr_i       = 32'h0;
        mem_store_data_i = 32'h0;
        flush_i          = 1'b0;
        mem_ack_i        = 1'b0;
        mem_rdata_i      = 32'h0;
    endtask

    task automatic drive_op(input logic [7:0] op, input logic [31:0] addr,
                            input logic [4:0] dst, input logic [31:0] st);
        alu_op_i         = op;
        write_reg_en_i   = 1'b1;
        write_reg_addr_i = dst;
        write_reg_data_i = addr;
        mem_addr_i       = addr;
        mem_store_data_i = st;
    endtask

    task automatic test_reset();
        drive_idle();
        rst = 1'b1;
        tick();
        tick();
        n_checks++;
        if ({mem_req_o, mem_we_o, mem_addr_o, mem_sel_o, mem_wdata_o, write_reg_en_o,
             write_reg_addr_o, write_reg_data_o, stall_req_o, misalign_o, bus_err_o} !== '0) begin
            n_fail++;
            $display("FAIL reset_outputs: req=%b en=%b stall=%b addr=%h, required all zero",
                     mem_req_o, write_reg_en_o, stall_req_o, mem_addr_o);
        end
        rst = 1'b0;
        tick();
    endtask

    task automatic test_nonmem();
        drive_op(8'h25, 32'h0, 5'd5, 32'h0);
        write_reg_data_i = 32'h0000_1234;
        tick();
        n_checks++;
        if ({write_reg_en_o, write_reg_addr_o, write_reg_data_o, stall_req_o} !==
            {1'b1, 5'd5, 32'h0000_1234, 1'b0}) begin
            n_fail++;
            $display("FAIL nonmem_wb: en=%b addr=%0d data=%h stall=%b, required 1 5 00001234 0",
                     write_reg_en_o, write_reg_addr_o, write_reg_data_o, stall_req_o);
        end
    endtask

    task automatic test_back_to_back();
        drive_op(8'h10, 32'h0, 5'd9, 32'h0);
        write_reg_data_i = 32'hCAFE_0001;
        tick();
        drive_op(8'h11, 32'h0, 5'd10, 32'h0);
        write_reg_en_i   = 1'b0;
        write_reg_data_i = 32'hCAFE_0002;
        n_checks++;
        if ({write_reg_en_o, write_reg_addr_o, write_reg_data_o} !== {1'b1, 5'd9, 32'hCAFE_0001}) begin
            n_fail++;
            $display("FAIL b2b_first: en=%b addr=%0d data=%h, required 1 9 cafe0001",
                     write_reg_en_o, write_reg_addr_o, write_reg_data_o);
        end
        tick();
        n_checks++;
        if ({write_reg_en_o, write_reg_addr_o, write_reg_data_o} !== {1'b0, 5'd10, 32'hCAFE_0002}) begin
            n_fail++;
            $display("FAIL b2b_second: en=%b addr=%0d data=%h, required 0 10 cafe0002",
                     write_reg_en_o, write_reg_addr_o, write_reg_data_o);
        end
        drive_idle();
        tick();
    endtask

    task automatic test_lb();
        int stall_cycles;
        drive_op(8'hE0, 32'h1000_0002, 5'd7, 32'h0);
        tick();
        drive_idle();
        n_checks++;
        if ({mem_req_o, mem_we_o, mem_sel_o, mem_addr_o} !== {1'b1, 1'b0, 4'b0010, 32'h1000_0000}) begin
            n_fail++;
            $display("FAIL lb_request: req=%b we=%b sel=%b addr=%h, required 1 0 0010 10000000",
                     mem_req_o, mem_we_o, mem_sel_o, mem_addr_o);
        end
        stall_cycles = stall_req_o ? 1 : 0;
        tick();
        stall_cycles += stall_req_o ? 1 : 0;
        tick();
        stall_cycles += stall_req_o ? 1 : 0;
        mem_ack_i   = 1'b1;
        mem_rdata_i = 32'h1122_8344;
        tick();
        mem_ack_i = 1'b0;
        stall_cycles += stall_req_o ? 1 : 0;
        n_checks++;
        if (stall_cycles !== 3) begin
            n_fail++;
            $display("FAIL lb_stall_cycles: got %0d, required 3", stall_cycles);
        end
        n_checks++;
        if ({write_reg_en_o, write_reg_addr_o, write_reg_data_o, mem_req_o} !==
            {1'b1, 5'd7, 32'hFFFF_FF83, 1'b0}) begin
            n_fail++;
            $display("FAIL lb_writeback: en=%b addr=%0d data=%h req=%b, required 1 7 ffffff83 0",
                     write_reg_en_o, write_reg_addr_o, write_reg_data_o, mem_req_o);
        end
    endtask

    task automatic test_lhu();
        drive_op(8'hE5, 32'h0000_0040, 5'd4, 32'h0);
        tick();
        drive_idle();
        mem_ack_i   = 1'b1;
        mem_rdata_i = 32'h8765_4321;
        tick();
        mem_ack_i = 1'b0;
        n_checks++;
        if ({write_reg_en_o, write_reg_data_o} !== {1'b1, 32'h0000_8765}) begin
            n_fail++;
            $display("FAIL lhu_extract: en=%b data=%h, required 1 00008765",
                     write_reg_en_o, write_reg_data_o);
        end
    endtask

    task automatic test_stores();
        drive_op(8'hE9, 32'h2000_0002, 5'd3, 32'h0000_ABCD);
        tick();
        drive_idle();
        n_checks++;
        if ({mem_req_o, mem_we_o, mem_sel_o, mem_wdata_o, mem_addr_o} !==
            {1'b1, 1'b1, 4'b0011, 32'hABCD_ABCD, 32'h2000_0000}) begin
            n_fail++;
            $display("FAIL sh_request: req=%b we=%b sel=%b wdata=%h addr=%h, required 1 1 0011 abcdabcd 20000000",
                     mem_req_o, mem_we_o, mem_sel_o, mem_wdata_o, mem_addr_o);
        end
        mem_ack_i = 1'b1;
        tick();
        mem_ack_i = 1'b0;
        n_checks++;
        if ({write_reg_en_o, mem_req_o, stall_req_o} !== 3'b000) begin
            n_fail++;
            $display("FAIL sh_complete: en=%b req=%b stall=%b, required 0 0 0",
                     write_reg_en_o, mem_req_o, stall_req_o);
        end
        drive_op(8'hE8, 32'h3000_0001, 5'd3, 32'h1234_5678);
        tick();
        drive_idle();
        n_checks++;
        if ({mem_sel_o, mem_wdata_o} !== {4'b0100, 32'h7878_7878}) begin
            n_fail++;
            $display("FAIL sb_lanes: sel=%b wdata=%h, required 0100 78787878", mem_sel_o, mem_wdata_o);
        end
        mem_ack_i = 1'b1;
        tick();
        mem_ack_i = 1'b0;
    endtask

    task automatic test_misalign();
        drive_op(8'hE3, 32'h4000_0001, 5'd6, 32'h0);
        tick();
        drive_idle();
        n_checks++;
        if ({mem_req_o, misalign_o, write_reg_en_o, stall_req_o} !== 4'b0100) begin
            n_fail++;
            $display("FAIL lw_misalign: req=%b misalign=%b en=%b stall=%b, required 0 1 0 0",
                     mem_req_o, misalign_o, write_reg_en_o, stall_req_o);
        end
        tick();
        n_checks++;
        if ({mem_req_o, misalign_o} !== 2'b00) begin
            n_fail++;
            $display("FAIL misalign_pulse: req=%b misalign=%b, required 0 0", mem_req_o, misalign_o);
        end
    endtask

    task automatic test_timeout();
        int req_cycles;
        drive_op(8'hE3, 32'h5000_0000, 5'd8, 32'h0);
        tick();
        drive_idle();
        req_cycles = 0;
        for (int i = 0; i < 20 && mem_req_o; i++) begin
            req_cycles++;
            tick();
        end
        n_checks++;
        if (req_cycles !== 8) begin
            n_fail++;
            $display("FAIL timeout_req_cycles: got %0d, required 8", req_cycles);
        end
        n_checks++;
        if ({bus_err_o, stall_req_o, write_reg_en_o} !== 3'b100) begin
            n_fail++;
            $display("FAIL timeout_abort: bus_err=%b stall=%b en=%b, required 1 0 0",
                     bus_err_o, stall_req_o, write_reg_en_o);
        end
        tick();
        n_checks++;
        if (bus_err_o !== 1'b0) begin
            n_fail++;
            $display("FAIL bus_err_pulse: bus_err=%b, required 0", bus_err_o);
        end
        // Ack on the final allowed cycle must complete the load normally.
        drive_op(8'hE3, 32'h5000_0004, 5'd8, 32'h0);
        tick();
        drive_idle();
        for (int i = 0; i < 7; i++) tick();
        mem_ack_i   = 1'b1;
        mem_rdata_i = 32'hDEAD_BEEF;
        tick();
        mem_ack_i = 1'b0;
        n_checks++;
        if ({write_reg_en_o, write_reg_data_o, bus_err_o, mem_req_o} !== {1'b1, 32'hDEAD_BEEF, 1'b0, 1'b0}) begin
            n_fail++;
            $display("FAIL ack_wins_timeout: en=%b data=%h bus_err=%b req=%b, required 1 deadbeef 0 0",
                     write_reg_en_o, write_reg_data_o, bus_err_o, mem_req_o);
        end
    endtask

    task automatic test_flush();
        drive_op(8'hE3, 32'h6000_0000, 5'd2, 32'h0);
        tick();
        drive_idle();
        tick();
        flush_i = 1'b1;
        tick();
        flush_i = 1'b0;
        n_checks++;
        if ({mem_req_o, stall_req_o} !== 2'b11) begin
            n_fail++;
            $display("FAIL flush_keeps_bus: req=%b stall=%b, required 1 1", mem_req_o, stall_req_o);
        end
        mem_ack_i   = 1'b1;
        mem_rdata_i = 32'h1111_2222;
        tick();
        mem_ack_i = 1'b0;
        n_checks++;
        if ({write_reg_en_o, mem_req_o} !== 2'b00) begin
            n_fail++;
            $display("FAIL flush_discard: en=%b req=%b, required 0 0", write_reg_en_o, mem_req_o);
        end
        drive_op(8'hE3, 32'h6000_0008, 5'd2, 32'h0);
        tick();
        drive_idle();
        mem_ack_i = 1'b1;
        flush_i   = 1'b1;
        tick();
        drive_idle();
        n_checks++;
        if ({write_reg_en_o, mem_req_o} !== 2'b00) begin
            n_fail++;
            $display("FAIL flush_with_ack: en=%b req=%b, required 0 0", write_reg_en_o, mem_req_o);
        end
        drive_op(8'h25, 32'h0, 5'd5, 32'h0);
        flush_i = 1'b1;
        tick();
        drive_idle();
        n_checks++;
        if (write_reg_en_o !== 1'b0) begin
            n_fail++;
            $display("FAIL flush_idle: en=%b, required 0", write_reg_en_o);
        end
    endtask

    task automatic test_ack_outside_bus();
        mem_ack_i   = 1'b1;
        mem_rdata_i = 32'hFFFF_FFFF;
        tick();
        mem_ack_i = 1'b0;
        n_checks++;
        if ({write_reg_en_o, mem_req_o, stall_req_o} !== 3'b000) begin
            n_fail++;
            $display("FAIL stray_ack: en=%b req=%b stall=%b, required 0 0 0",
                     write_reg_en_o, mem_req_o, stall_req_o);
        end
    endtask

    task automatic test_rst_in_bus();
        drive_op(8'hE3, 32'h7000_0000, 5'd1, 32'h0);
        tick();
        drive_idle();
        tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        n_checks++;
        if ({mem_req_o, mem_we_o, mem_addr_o, mem_sel_o, stall_req_o, write_reg_en_o,
             write_reg_data_o, bus_err_o} !== '0) begin
            n_fail++;
            $display("FAIL rst_in_bus: req=%b addr=%h sel=%b stall=%b en=%b, required all zero",
                     mem_req_o, mem_addr_o, mem_sel_o, stall_req_o, write_reg_en_o);
        end
        tick();
        n_checks++;
        if ({mem_req_o, stall_req_o} !== 2'b00) begin
            n_fail++;
            $display("FAIL rst_back_idle: req=%b stall=%b, required 0 0", mem_req_o, stall_req_o);
        end
    endtask

    initial begin
        rst = 1'b1;
        drive_idle();
        test_reset();
        test_nonmem();
        test_back_to_back();
        test_lb();
        test_lhu();
        test_stores();
        test_misalign();
        test_timeout();
        test_flush();
        test_ack_outside_bus();
        test_rst_in_bus();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
